// File: rtl/issue_pair_dispatch_if.sv
// Decode-to-dispatch and dispatch-to-ID/EX signal bundle for the dual-issue dispatcher.
// Pure wiring: no storage. Latency and registering are owned by the dispatcher.
// Backpressure travels on dec_ready; ex_stall and flush come from the pipeline control.
interface issue_pair_dispatch_if #(
    parameter int STAGE_WIDTH = 32
);
    // Decode side: the presented instruction pair and its qualifiers.
    logic                   dec_valid;
    logic                   dec_valid1;
    logic [STAGE_WIDTH-1:0] dec_instr0;
    logic [STAGE_WIDTH-1:0] dec_instr1;
    logic                   dec_unicorn0;
    logic                   dec_unicorn1;
    logic                   dec_ready;

    // Pipeline control.
    logic                   ex_stall;
    logic                   flush;

    // Issue side: registered per-slot outputs into the ID/EX registers.
    logic                   iss_valid0;
    logic [STAGE_WIDTH-1:0] iss_instr0;
    logic                   iss_valid1;
    logic [STAGE_WIDTH-1:0] iss_instr1;
    logic                   split_active;

    // Environment view: decode and pipeline control drive, issue outputs are observed.
    modport master (
        output dec_valid,
        output dec_valid1,
        output dec_instr0,
        output dec_instr1,
        output dec_unicorn0,
        output dec_unicorn1,
        input  dec_ready,
        output ex_stall,
        output flush,
        input  iss_valid0,
        input  iss_instr0,
        input  iss_valid1,
        input  iss_instr1,
        input  split_active
    );

    // Dispatcher view.
    modport slave (
        input  dec_valid,
        input  dec_valid1,
        input  dec_instr0,
        input  dec_instr1,
        input  dec_unicorn0,
        input  dec_unicorn1,
        output dec_ready,
        input  ex_stall,
        input  flush,
        output iss_valid0,
        output iss_instr0,
        output iss_valid1,
        output iss_instr1,
        output split_active
    );
endinterface

// File: rtl/issue_pair_dispatch.sv
// Dual-issue dispatcher: issues decoded pairs to ID/EX slots 0/1, serialising pairs that cannot co-issue.
// Latency: 1 cycle from acceptance to iss_*; a split pair takes 2 cycles (slot 0, then slot 1).
// Backpressure: dec_ready drops during SPLIT, ex_stall or flush; optional intra-pair RAW split under DISPATCH_RAW_CHECK_EN.
module issue_pair_dispatch #(
    parameter int STAGE_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    issue_pair_dispatch_if.slave io
);

    typedef enum logic {
        RUN   = 1'b0,
        SPLIT = 1'b1
    } state_t;

    state_t                 state;
    logic [STAGE_WIDTH-1:0] pending;
    logic                   valid0_q;
    logic                   valid1_q;
    logic [STAGE_WIDTH-1:0] instr0_q;
    logic [STAGE_WIDTH-1:0] instr1_q;

    logic                   raw_hit;
    logic                   split_cond;
    logic                   accept;

`ifdef DISPATCH_RAW_CHECK_EN
    logic [4:0]             rd0;
    logic [4:0]             rs1_1;
    logic [4:0]             rs2_1;

    // Slot 1 reads the register slot 0 writes (x0 never creates a dependency).
    always_comb begin
        rd0     = io.dec_instr0[11:7];
        rs1_1   = io.dec_instr1[19:15];
        rs2_1   = io.dec_instr1[24:20];
        raw_hit = (rd0 != 5'd0) && ((rd0 == rs1_1) || (rd0 == rs2_1));
    end
`else
    // Decode only presents independent pairs, so no dependency check is needed.
    always_comb begin
        raw_hit = 1'b0;
    end
`endif

    // A lone slot 0 instruction never needs splitting, even if it must issue alone.
    assign split_cond = io.dec_valid1 & (io.dec_unicorn0 | io.dec_unicorn1 | raw_hit);

    assign io.dec_ready = ~io.flush & ~io.ex_stall & (state == RUN);
    assign accept       = io.dec_valid & io.dec_ready;

    // Dispatch FSM with registered slot outputs; priority is flush, then stall, then normal flow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RUN;
            pending  <= '0;
            valid0_q <= 1'b0;
            valid1_q <= 1'b0;
            instr0_q <= '0;
            instr1_q <= '0;
        end else if (io.flush) begin
            state    <= RUN;
            pending  <= '0;
            valid0_q <= 1'b0;
            valid1_q <= 1'b0;
            instr0_q <= '0;
            instr1_q <= '0;
        end else if (io.ex_stall) begin
            state    <= state;
        end else begin
            unique case (state)
                RUN: begin
                    if (!accept) begin
                        valid0_q <= 1'b0;
                        valid1_q <= 1'b0;
                        instr0_q <= '0;
                        instr1_q <= '0;
                    end else if (split_cond) begin
                        // Slot 0 goes now; slot 1 is parked and keeps its slot on the next cycle.
                        valid0_q <= 1'b1;
                        instr0_q <= io.dec_instr0;
                        valid1_q <= 1'b0;
                        instr1_q <= '0;
                        pending  <= io.dec_instr1;
                        state    <= SPLIT;
                    end else begin
                        valid0_q <= 1'b1;
                        instr0_q <= io.dec_instr0;
                        valid1_q <= io.dec_valid1;
                        instr1_q <= io.dec_valid1 ? io.dec_instr1 : '0;
                    end
                end
                SPLIT: begin
                    valid0_q <= 1'b0;
                    instr0_q <= '0;
                    valid1_q <= 1'b1;
                    instr1_q <= pending;
                    pending  <= '0;
                    state    <= RUN;
                end
                default: begin
                    state    <= RUN;
                end
            endcase
        end
    end

    assign io.iss_valid0   = valid0_q;
    assign io.iss_instr0   = instr0_q;
    assign io.iss_valid1   = valid1_q;
    assign io.iss_instr1   = instr1_q;
    assign io.split_active = (state == SPLIT);

endmodule

// File: tb/tb_issue_pair_dispatch.sv
// Directed bench for issue_pair_dispatch: pairs, unicorn splits, stall, flush, reset and RAW pairs.
// Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
// Expected values are hand-derived; RAW expectations follow DISPATCH_RAW_CHECK_EN.
module tb_issue_pair_dispatch;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    issue_pair_dispatch_if #(.STAGE_WIDTH(32)) bus ();

    issue_pair_dispatch #(.STAGE_WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic v0, input logic [31:0] i0,
                           input logic v1, input logic [31:0] i1, input logic sa);
        chk({tag, ".valid0"}, {31'd0, bus.iss_valid0}, {31'd0, v0});
        chk({tag, ".instr0"}, bus.iss_instr0, i0);
        chk({tag, ".valid1"}, {31'd0, bus.iss_valid1}, {31'd0, v1});
        chk({tag, ".instr1"}, bus.iss_instr1, i1);
        chk({tag, ".split"},  {31'd0, bus.split_active}, {31'd0, sa});
    endtask

    task automatic present(input logic v, input logic v1, input logic [31:0] i0,
                           input logic [31:0] i1, input logic u0, input logic u1);
        bus.dec_valid    = v;
        bus.dec_valid1   = v1;
        bus.dec_instr0   = i0;
        bus.dec_instr1   = i1;
        bus.dec_unicorn0 = u0;
        bus.dec_unicorn1 = u1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        bus.ex_stall = 1'b0;
        bus.flush    = 1'b0;
        present(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        #2;
        chk_out("reset_async", 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        step();
        step();
        rst_n = 1'b1;
        step();
        chk_out("reset_idle", 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        chk("reset_ready", {31'd0, bus.dec_ready}, 32'd1);

        // Independent pair, then a second one back to back.
        present(1'b1, 1'b1, 32'h00100093, 32'h00200113, 1'b0, 1'b0);
        #1 chk("pair1_ready", {31'd0, bus.dec_ready}, 32'd1);
        step();
        chk_out("pair1", 1'b1, 32'h00100093, 1'b1, 32'h00200113, 1'b0);
        present(1'b1, 1'b1, 32'h00300193, 32'h00400213, 1'b0, 1'b0);
        #1 chk("pair2_ready", {31'd0, bus.dec_ready}, 32'd1);
        step();
        chk_out("pair2", 1'b1, 32'h00300193, 1'b1, 32'h00400213, 1'b0);

        // Lone unicorn never splits; the absent slot carries zero even if decode drives junk.
        present(1'b1, 1'b0, 32'h30001073, 32'hdeadbeef, 1'b1, 1'b0);
        step();
        chk_out("lone_unicorn", 1'b1, 32'h30001073, 1'b0, 32'h0, 1'b0);
        chk("lone_unicorn_ready", {31'd0, bus.dec_ready}, 32'd1);

        // Unicorn in slot 0 splits the pair.
        present(1'b1, 1'b1, 32'h30001073, 32'h00100093, 1'b1, 1'b0);
        step();
        chk_out("uni0_t1", 1'b1, 32'h30001073, 1'b0, 32'h0, 1'b1);
        chk("uni0_t1_ready", {31'd0, bus.dec_ready}, 32'd0);
        present(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        step();
        chk_out("uni0_t2", 1'b0, 32'h0, 1'b1, 32'h00100093, 1'b0);
        chk("uni0_t2_ready", {31'd0, bus.dec_ready}, 32'd1);

        // Unicorn in slot 1, with a 3-cycle stall while the second half is pending.
        present(1'b1, 1'b1, 32'h00500293, 32'h30002073, 1'b0, 1'b1);
        step();
        chk_out("stall_t1", 1'b1, 32'h00500293, 1'b0, 32'h0, 1'b1);
        present(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        bus.ex_stall = 1'b1;
        #1 chk("stall_ready", {31'd0, bus.dec_ready}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk_out("stall_hold", 1'b1, 32'h00500293, 1'b0, 32'h0, 1'b1);
        end
        bus.ex_stall = 1'b0;
        step();
        chk_out("stall_release", 1'b0, 32'h0, 1'b1, 32'h30002073, 1'b0);
        chk("stall_release_ready", {31'd0, bus.dec_ready}, 32'd1);

        // Flush while split: the pending half is discarded.
        present(1'b1, 1'b1, 32'h30001073, 32'h00700393, 1'b1, 1'b0);
        step();
        chk_out("flush_t1", 1'b1, 32'h30001073, 1'b0, 32'h0, 1'b1);
        present(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        bus.flush = 1'b1;
        #1 chk("flush_ready", {31'd0, bus.dec_ready}, 32'd0);
        step();
        chk_out("flush_t2", 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        bus.flush = 1'b0;
        step();
        chk_out("flush_t3", 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        chk("flush_t3_ready", {31'd0, bus.dec_ready}, 32'd1);

        // Stall in RUN holds issued pair and refuses the next one.
        present(1'b1, 1'b1, 32'h00100093, 32'h00200113, 1'b0, 1'b0);
        step();
        present(1'b1, 1'b1, 32'h00800413, 32'h00900493, 1'b0, 1'b0);
        bus.ex_stall = 1'b1;
        #1 chk("run_stall_ready", {31'd0, bus.dec_ready}, 32'd0);
        step();
        chk_out("run_stall_hold", 1'b1, 32'h00100093, 1'b1, 32'h00200113, 1'b0);
        bus.ex_stall = 1'b0;
        step();
        chk_out("run_stall_resume", 1'b1, 32'h00800413, 1'b1, 32'h00900493, 1'b0);

        // Flush and stall together with a pair presented: flush wins, nothing accepted.
        bus.flush    = 1'b1;
        bus.ex_stall = 1'b1;
        #1 chk("flush_stall_ready", {31'd0, bus.dec_ready}, 32'd0);
        step();
        chk_out("flush_stall", 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        bus.flush    = 1'b0;
        bus.ex_stall = 1'b0;
        present(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        step();
        chk_out("bubble", 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);

        // Dependent pair addi x1 -> add x3,x1,x2.
        present(1'b1, 1'b1, 32'h00100093, 32'h002081B3, 1'b0, 1'b0);
        step();
        present(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
`ifdef DISPATCH_RAW_CHECK_EN
        chk_out("raw_t1", 1'b1, 32'h00100093, 1'b0, 32'h0, 1'b1);
        step();
        chk_out("raw_t2", 1'b0, 32'h0, 1'b1, 32'h002081B3, 1'b0);
`else
        chk_out("raw_t1", 1'b1, 32'h00100093, 1'b1, 32'h002081B3, 1'b0);
        step();
        chk_out("raw_t2", 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
`endif

        // x0 destination never creates a dependency.
        present(1'b1, 1'b1, 32'h00000013, 32'h00000033, 1'b0, 1'b0);
        step();
        chk_out("rd0_zero", 1'b1, 32'h00000013, 1'b1, 32'h00000033, 1'b0);

        // Reset asserted mid-split clears outputs immediately and loses the pending half.
        present(1'b1, 1'b1, 32'h30001073, 32'h00a00513, 1'b1, 1'b0);
        step();
        chk_out("rst_split_t1", 1'b1, 32'h30001073, 1'b0, 32'h0, 1'b1);
        present(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1 chk_out("rst_mid_split", 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        step();
        rst_n = 1'b1;
        step();
        chk_out("rst_after", 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        chk("rst_after_ready", {31'd0, bus.dec_ready}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/issue_pair_dispatch.md
# issue_pair_dispatch

Dual-issue dispatcher between the decode stage and the two ID/EX pipeline registers (slot 0, slot 1). It accepts a decoded instruction pair from decode and drives registered per-slot instructions and valids into the pipeline. Pairs that cannot issue together are serialised over two cycles: slot 0 first, then slot 1. This covers pairs containing a "unicorn" instruction (must issue alone: CSR, fence, mul/div) and, optionally, pairs with an intra-pair RAW hazard. Decode is back-pressured for the duration.

## Interface
Parameters:
- STAGE_WIDTH, default 32: width of one decoded instruction word. Must be ≥ 32; bits [31:0] hold the RISC-V encoding.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- dec_valid  in  1  decode presents a pair; slot 0 is always occupied when high.
- dec_valid1  in  1  slot 1 of the presented pair is occupied. Ignored when dec_valid=0.
- dec_instr0  in  STAGE_WIDTH  slot 0 instruction.
- dec_instr1  in  STAGE_WIDTH  slot 1 instruction.
- dec_unicorn0  in  1  slot 0 instruction must issue alone.
- dec_unicorn1  in  1  slot 1 instruction must issue alone.
- dec_ready  out  1  pair accepted this cycle when dec_valid & dec_ready.
- ex_stall  in  1  downstream stall; all state and outputs hold.
- flush  in  1  pipeline flush; kills everything in the dispatcher.
- iss_valid0  out  1  slot 0 output valid.
- iss_instr0  out  STAGE_WIDTH  slot 0 instruction to ID/EX slot 0.
- iss_valid1  out  1  slot 1 output valid.
- iss_instr1  out  STAGE_WIDTH  slot 1 instruction to ID/EX slot 1.
- split_active  out  1  high while in SPLIT (second half of a serialised pair pending).

## Operation
- The FSM has two states:
  - RUN: reset state.
  - SPLIT: holds a pending slot 1 instruction in an internal register.
- dec_ready = ~flush & ~ex_stall & (state==RUN). This is combinational.
- split_cond = dec_valid1 & (dec_unicorn0 | dec_unicorn1 | raw_hit). The raw_hit term exists only when configured; see Configuration.
- A lone slot 0 instruction (dec_valid1=0) never splits, even when it is a unicorn.
- Each clock edge, priority is flush > ex_stall > normal.
  - flush: iss_valid0/1 ← 0 and iss_instr0/1 ← 0. Pending instruction discarded, state ← RUN.
  - ex_stall: every register holds its value.
  - RUN with dec_valid=0: bubble. Both valids ← 0, both instrs ← 0.
  - RUN with dec_valid=1 and split_cond=0:
    - iss_instr0 ← dec_instr0, iss_valid0 ← 1.
    - iss_instr1 ← dec_valid1 ? dec_instr1 : 0, iss_valid1 ← dec_valid1.
  - RUN with dec_valid=1 and split_cond=1:
    - iss_instr0 ← dec_instr0, iss_valid0 ← 1.
    - iss_valid1 ← 0, iss_instr1 ← 0.
    - pending ← dec_instr1, state ← SPLIT.
  - SPLIT:
    - iss_valid0 ← 0, iss_instr0 ← 0.
    - iss_instr1 ← pending, iss_valid1 ← 1.
    - state ← RUN.
- A slot 1 instruction always issues on slot 1, never moved to slot 0, so ID/EX slot mapping is preserved.
- Invalid slots always carry instruction 0 (NOP/bubble encoding shared with flush).
- split_active = (state==SPLIT).

## Timing
- Reset values: iss_valid0=0, iss_valid1=0, iss_instr0=0, iss_instr1=0, state=RUN, pending=0. split_active=0. dec_ready reflects inputs (1 when flush=0 and ex_stall=0).
- Latency: accepted pair appears on iss_* on the next edge (1 cycle).
- Split pair: slot 0 issues at T+1 and slot 1 at T+2. dec_ready=0 during the cycle after acceptance, so throughput is one pair per 2 cycles.
- ex_stall while in SPLIT: the pending instruction is held and issues on the first unstalled edge.
- flush and ex_stall in the same cycle: flush wins.
- flush and dec_valid in the same cycle: the pair is not accepted (dec_ready=0).
- Reset asserted mid-split: the pending instruction is lost and outputs clear asynchronously.

## Configuration
- DISPATCH_RAW_CHECK_EN defined:
  - rd0 = dec_instr0[11:7].
  - raw_hit = (rd0≠0) & (rd0==dec_instr1[19:15] | rd0==dec_instr1[24:20]).
  - A dependent pair is split.
- Not defined: raw_hit is constant 0. Decode guarantees that pairs presented together are independent.

## Test plan
- Reset release, dec_valid=0 → all iss_* = 0, split_active=0, dec_ready=1.
- Independent pair 0x00100093/0x00200113 (dec_valid1=1, no unicorn) → next cycle both valids 1 with those instrs. A back-to-back second pair is accepted every cycle.
- Pair with dec_unicorn0=1 (0x30001073, 0x00100093):
  - T+1: iss_valid0=1 with 0x30001073, iss_valid1=0.
  - T+2: iss_valid0=0, iss_valid1=1 with 0x00100093.
  - dec_ready=0 during T+1.
- Split pair with ex_stall=1 for 3 cycles after T+1 → outputs frozen. Slot 1 issues on the first unstalled edge, then dec_ready returns to 1.
- flush asserted while split_active=1 → next cycle both valids 0, both instrs 0, state RUN. The pending instruction never issues.
- With DISPATCH_RAW_CHECK_EN, pair addi x1 (0x00100093) followed by add x3,x1,x2 (0x002081B3) → split over 2 cycles. Without the macro, the same pair issues together.
